// File: rtl/seq_det_pkg.sv
// Shared constants and mode type for the parametrised Moore sequence detector.
package seq_det_pkg;

    localparam int          DEFAULT_PAT_W = 4;
    localparam int          DEFAULT_CNT_W = 8;
    localparam logic [3:0]  PAT_1100      = 4'b1100;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } det_mode_t;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = DEFAULT_CNT_W
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, increment stops at the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {W{1'b0}};
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detect_param_moore.sv
// Parametrised Moore serial-pattern detector with loadable pattern and saturating match count.
// Optional feature: define SEQ_DET_MASK_EN to add a per-bit care_mask captured on pat_load.
module seq_detect_param_moore
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = DEFAULT_PAT_W,
    parameter int               CNT_W       = DEFAULT_CNT_W,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(PAT_1100)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] care_mask,
`endif
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  sr_q;
    logic [FILL_W-1:0] fill_q;
    logic              y_q;
    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  mask_s;

    logic [PAT_W-1:0]  sr_d;
    logic [FILL_W-1:0] fill_inc_s;
    logic [FILL_W-1:0] fill_d;
    logic              hit_s;
    logic              shift_en_s;
    det_mode_t         mode_s;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask_q;

    // Care mask is loaded alongside the pattern; all-ones means exact compare.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mask_q <= {PAT_W{1'b1}};
        end else if (pat_load) begin
            mask_q <= care_mask;
        end else begin
            mask_q <= mask_q;
        end
    end

    assign mask_s = mask_q;
`else
    assign mask_s = {PAT_W{1'b1}};
`endif

    // Candidate shift, saturating fill and hit decision for a valid bit.
    always_comb begin
        sr_d       = {sr_q[PAT_W-2:0], x};
        shift_en_s = x_valid && !pat_load;
        mode_s     = det_mode_t'(overlap);
        if (fill_q >= FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_q + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        hit_s = (fill_inc_s == FILL_FULL) && (((sr_d ^ pattern_q) & mask_s) == {PAT_W{1'b0}});
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        fill_d = fill_inc_s;
        if (hit_s) begin
            case (mode_s)
                MODE_OVL:    fill_d = fill_inc_s;
                MODE_NONOVL: fill_d = {FILL_W{1'b0}};
                default:     fill_d = fill_inc_s;
            endcase
        end else begin
            fill_d = fill_inc_s;
        end
    end

    // Detector state: reset, then pattern load, then valid shift; otherwise hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sr_q      <= {PAT_W{1'b0}};
            fill_q    <= {FILL_W{1'b0}};
            y_q       <= 1'b0;
            pattern_q <= DEFAULT_PAT;
        end else if (pat_load) begin
            sr_q      <= {PAT_W{1'b0}};
            fill_q    <= {FILL_W{1'b0}};
            y_q       <= 1'b0;
            pattern_q <= pat_in;
        end else if (shift_en_s) begin
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            y_q       <= hit_s;
            pattern_q <= pattern_q;
        end else begin
            sr_q      <= sr_q;
            fill_q    <= fill_q;
            y_q       <= y_q;
            pattern_q <= pattern_q;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk_i   (Clock),
        .clr_i   (Reset),
        .inc_i   (shift_en_s && hit_s),
        .count_o (match_count)
    );

    assign y       = y_q;
    assign pattern = pattern_q;

endmodule

// File: tb/tb_seq_detect_param_moore.sv
// Directed bench for seq_detect_param_moore with a queue-based reference model and literal spot checks.
module tb_seq_detect_param_moore;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic [3:0] mask_in = 4'b1111;

    logic       y_a, y_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [3:0] pat_a, pat_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    seq_detect_param_moore dut (
        .Clock(Clock), .Reset(Reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
        .care_mask(mask_in),
`endif
        .y(y_a), .match_count(cnt_a), .pattern(pat_a)
    );

    seq_detect_param_moore #(.CNT_W(2)) dut_c2 (
        .Clock(Clock), .Reset(Reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
        .care_mask(mask_in),
`endif
        .y(y_b), .match_count(cnt_b), .pattern(pat_b)
    );

    // Reference model: bits received since the last clear, newest at the back.
    bit       hist[$];
    logic [3:0] pat_m  = 4'b1100;
    logic [3:0] mask_m = 4'b1111;
    logic       y_m    = 1'b0;
    int         c8_m   = 0;
    int         c2_m   = 0;
    bit         chk_en = 1'b0;

    function automatic bit model_hit();
        if (hist.size() < 4) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mask_m[i] && (hist[hist.size() - 1 - i] != pat_m[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            hist.delete();
            y_m = 1'b0; c8_m = 0; c2_m = 0;
            pat_m = 4'b1100; mask_m = 4'b1111;
            chk_en = 1'b1;
        end else if (pat_load) begin
            hist.delete();
            y_m = 1'b0;
            pat_m = pat_in;
`ifdef SEQ_DET_MASK_EN
            mask_m = mask_in;
`endif
        end else if (x_valid) begin
            hist.push_back(x);
            if (hist.size() > 4) void'(hist.pop_front());
            y_m = model_hit();
            if (y_m) begin
                if (c8_m < 255) c8_m++;
                if (c2_m < 3) c2_m++;
                if (!overlap) hist.delete();
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (chk_en) begin
            check("model_y",     int'(y_a),   int'(y_m));
            check("model_cnt",   int'(cnt_a), c8_m);
            check("model_pat",   int'(pat_a), int'(pat_m));
            check("model_y_c2",  int'(y_b),   int'(y_m));
            check("model_cnt_c2", int'(cnt_b), c2_m);
            check("model_pat_c2", int'(pat_b), int'(pat_m));
        end
    end

    task automatic drive(input logic rst, input logic v, input logic b, input logic ld,
                         input logic [3:0] pin, input logic [3:0] msk);
        @(negedge Clock);
        #1;
        Reset = rst; x_valid = v; x = b; pat_load = ld; pat_in = pin; mask_in = msk;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    endtask

    task automatic bit_in(input logic b);
        drive(1'b0, 1'b1, b, 1'b0, 4'b0000, 4'b1111);
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m);
        drive(1'b0, 1'b0, 1'b0, 1'b1, p, m);
    endtask

    logic [3:0] seq1100;
    int exp_c2[5];

    initial begin
        seq1100 = 4'b1100;
        exp_c2  = '{1, 2, 3, 3, 3};

        // 1: default pattern, overlapping
        overlap = 1'b1;
        do_reset();
        check("t1_reset_y", int'(y_a), 0);
        check("t1_reset_cnt", int'(cnt_a), 0);
        check("t1_reset_pat", int'(pat_a), 12);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        check("t1_y_early", int'(y_a), 0);
        bit_in(1'b0);
        check("t1_y_hit", int'(y_a), 1);
        check("t1_cnt", int'(cnt_a), 1);
        bit_in(1'b0);
        check("t1_y_drop", int'(y_a), 0);

        // 2: all-zero pattern cannot match before four bits
        do_reset();
        load(4'b0000, 4'b1111);
        bit_in(1'b0); bit_in(1'b0); bit_in(1'b0);
        check("t2_y_3zeros", int'(y_a), 0);
        bit_in(1'b0);
        check("t2_y_4zeros", int'(y_a), 1);
        bit_in(1'b0);
        check("t2_y_5zeros", int'(y_a), 1);
        check("t2_cnt", int'(cnt_a), 2);

        // 3: 1010 non-overlapping then overlapping
        do_reset();
        overlap = 1'b0;
        load(4'b1010, 4'b1111);
        for (int i = 0; i < 6; i++) bit_in(logic'(i % 2 == 0));
        check("t3_nonovl_y", int'(y_a), 0);
        check("t3_nonovl_cnt", int'(cnt_a), 1);
        do_reset();
        overlap = 1'b1;
        load(4'b1010, 4'b1111);
        for (int i = 0; i < 5; i++) bit_in(logic'(i % 2 == 0));
        check("t3_ovl_y_bit5", int'(y_a), 0);
        bit_in(1'b0);
        check("t3_ovl_y_bit6", int'(y_a), 1);
        check("t3_ovl_cnt", int'(cnt_a), 2);

        // 4: y holds through stall cycles, x ignored while invalid
        do_reset();
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, logic'(i % 2), 1'b0, 4'b0000, 4'b1111);
            check("t4_y_stall", int'(y_a), 1);
        end
        bit_in(1'b1);
        check("t4_y_after", int'(y_a), 0);
        check("t4_cnt", int'(cnt_a), 1);

        // 5: pattern load wins over a simultaneous valid bit
        do_reset();
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 4'b1111);
        check("t5_load_y", int'(y_a), 0);
        check("t5_load_pat", int'(pat_a), 6);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check("t5_y_3bits", int'(y_a), 0);
        bit_in(1'b0);
        check("t5_y_hit", int'(y_a), 1);

        // 6: counter saturation on the 2-bit instance, then reset mid-sequence
        do_reset();
        for (int h = 0; h < 5; h++) begin
            for (int i = 3; i >= 0; i--) bit_in(seq1100[i]);
            check("t6_cnt_c2", int'(cnt_b), exp_c2[h]);
            check("t6_cnt8", int'(cnt_a), h + 1);
        end
        load(4'b0110, 4'b1111);
        bit_in(1'b0); bit_in(1'b1);
        do_reset();
        check("t6_rst_y", int'(y_a), 0);
        check("t6_rst_cnt", int'(cnt_a), 0);
        check("t6_rst_cnt_c2", int'(cnt_b), 0);
        check("t6_rst_pat", int'(pat_a), 12);

`ifdef SEQ_DET_MASK_EN
        do_reset();
        load(4'b1001, 4'b1001);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        check("t7_mask_y", int'(y_a), 1);
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
